vga_timing_generator: RTL and testbench
=======================================

# vga_timing_generator

Raster scan generator and pixel output stage on the VGA side of the graphics controller. It produces the `vga_x_pos`/`vga_y_pos` coordinates that the sprite pipeline consumes, and samples the composed 24-bit colour that comes back. It drives the DAC/connector signals (`hsync`, `vsync`, `blank_n`, `sync_n`, 8-bit R/G/B). A fixed pipeline delay absorbs the sprite-ROM read latency, so the sync signals and the colour stay aligned.

## Interface
Parameters:
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP` / `H_SYNC` / `H_BP`, 16 / 96 / 48: horizontal front porch, sync width, back porch (clocks)
- `V_ACTIVE`, 480: visible lines
- `V_FP` / `V_SYNC` / `V_BP`, 10 / 2 / 33: vertical front porch, sync width, back porch (lines)
- `PIPE_DELAY`, 2: clocks from a coordinate on `x_pos_o`/`y_pos_o` to its colour on `r_o`/`g_o`/`b_o`; legal range 1..8

Ports:
- `vga_clk_i`  in  1  pixel clock, 25 MHz nominal; the only clock
- `rst_n_i`  in  1  reset, asynchronous, active-low
- `RGB_i`  in  24  composed pixel colour, {R[23:16], G[15:8], B[7:0]}
- `x_pos_o`  out  32  current horizontal count, zero-extended
- `y_pos_o`  out  32  current vertical count, zero-extended
- `hsync_o`  out  1  horizontal sync, active-low
- `vsync_o`  out  1  vertical sync, active-low
- `blank_n_o`  out  1  high while the delayed pixel is visible
- `sync_n_o`  out  1  DAC composite sync; constant 0
- `r_o`, `g_o`, `b_o`  out  8 each  pixel colour
- `frame_start_o`  out  1  one-cycle pulse at the start of each frame

## Operation
- Derived totals: `H_TOTAL` = `H_ACTIVE`+`H_FP`+`H_SYNC`+`H_BP` (800); `V_TOTAL` = `V_ACTIVE`+`V_FP`+`V_SYNC`+`V_BP` (525).
- Counters: `h_cnt` counts 0..`H_TOTAL`-1 and wraps to 0.
  - On that wrap, `v_cnt` increments, covering 0..`V_TOTAL`-1 and wrapping to 0.
  - Both counters are 10 bits internally.
- `x_pos_o` = `h_cnt` and `y_pos_o` = `v_cnt`, driven straight from the counter registers with no delay.
- Raw per-cycle flags:
  - `act` = (`h_cnt` < `H_ACTIVE`) and (`v_cnt` < `V_ACTIVE`)
  - `hs` = `h_cnt` in [`H_ACTIVE`+`H_FP`, `H_ACTIVE`+`H_FP`+`H_SYNC`-1], i.e. 656..751
  - `vs` = `v_cnt` in [`V_ACTIVE`+`V_FP`, `V_ACTIVE`+`V_FP`+`V_SYNC`-1], i.e. 490..491
- Delay line: `act`, `hs` and `vs` pass through a shift register of `PIPE_DELAY` stages.
  - `hsync_o` = NOT delayed `hs`.
  - `vsync_o` = NOT delayed `vs`.
  - `blank_n_o` = delayed `act`.
- Colour register:
  - Loaded every clock with `RGB_i` when delayed-`act` stage `PIPE_DELAY`-1 is 1; loaded with 0 otherwise.
  - `PIPE_DELAY`=1 uses raw `act`.
  - Result: `r_o`/`g_o`/`b_o` are exactly 0 whenever `blank_n_o`=0.
- `RGB_i` contract: colour for the coordinate shown at cycle t is valid at cycle t+`PIPE_DELAY`-1.
- `frame_start_o`: registered; set for one cycle when the counters move from (`H_TOTAL`-1, `V_TOTAL`-1) to (0,0). It is not delayed.

## Timing
- Reset values, held while `rst_n_i`=0:
  - counters 0, so `x_pos_o`=0 and `y_pos_o`=0
  - `hsync_o`=1, `vsync_o`=1, `blank_n_o`=0
  - `r_o`/`g_o`/`b_o`=0, `frame_start_o`=0
  - all delay stages reset to the inactive values
- Reset assertion takes effect immediately, without waiting for a clock, including mid-line or mid-frame. Release starts counting at the next rising edge.
- Cycle indexing: k counts rising edges since release, with k=0 being the reset state.
  - `h_cnt` = k mod 800
  - `v_cnt` = ⌊k/800⌋ mod 525
  - Frame length is 420000 clocks.
- With `PIPE_DELAY`=2:
  - `hsync_o` is low for k mod 800 in 658..753.
  - `blank_n_o` is high for k mod 800 in 2..641, on lines whose delayed `v_cnt` < 480.
  - `vsync_o` is low for k mod 420000 in 392002..393601.
- `frame_start_o` is high at k = 420000·m for m ≥ 1. There is no pulse for the reset-state (0,0).
- Latency from coordinate to colour output is exactly `PIPE_DELAY` clocks. There is no stall or backpressure.

## Test plan
- Reset: hold `rst_n_i`=0 for 10 clocks mid-frame → immediately `x_pos_o`=0, `y_pos_o`=0, `hsync_o`=1, `vsync_o`=1, `blank_n_o`=0, RGB=0. After release, `x_pos_o` = 1, 2, 3… on successive clocks.
- Horizontal: run 2 lines → `hsync_o` low for exactly 96 clocks starting at k=658 and k=1458; `x_pos_o` wraps 799→0 while `y_pos_o` goes 0→1.
- Vertical and frame: run 2 frames → `vsync_o` low for 1600 clocks starting at k=392002; `frame_start_o` single-cycle high at k=420000 and k=840000 only; `y_pos_o` wraps 524→0.
- Alignment: bench model returns `RGB_i`={x[7:0], y[7:0], 8'hA5} with a 1-clock delay → at every clock with `blank_n_o`=1, `r_o`/`g_o` equal the (x,y) shown 2 clocks earlier and `b_o`=A5. During blanking, RGB outputs are 0 even with `RGB_i`=FFFFFF.
- Reset mid-operation: assert `rst_n_i` at k=500000 for 3 clocks → outputs return to reset values asynchronously. After release, the timing from the first test reproduces exactly, and the next `frame_start_o` is at 420000 clocks after release.
- Parameter: `PIPE_DELAY`=1 → `hsync_o` low at k mod 800 in 657..752; colour aligned to a zero-latency `RGB_i` model.

Source files
------------

// File: rtl/vga_timing_generator.sv
// vga_timing_generator: raster counters, sync/blank generation and a fixed-delay
// pixel output stage that keeps sync, blank and colour aligned.
module vga_timing_generator #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int PIPE_DELAY = 2
) (
  input  logic        vga_clk_i,
  input  logic        rst_n_i,
  input  logic [23:0] RGB_i,
  output logic [31:0] x_pos_o,
  output logic [31:0] y_pos_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        blank_n_o,
  output logic        sync_n_o,
  output logic [7:0]  r_o,
  output logic [7:0]  g_o,
  output logic [7:0]  b_o,
  output logic        frame_start_o
);
  localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
  logic [9:0] h_cnt, v_cnt;
  logic h_end, v_end, act, hs, vs;
  logic [PIPE_DELAY-1:0] act_d, hs_d, vs_d;
  logic [PIPE_DELAY:0] act_v, hs_v, vs_v;
  logic [23:0] rgb;
  assign h_end = h_cnt == H_LAST;
  assign v_end = v_cnt == V_LAST;
  assign act = h_cnt < H_VIS && v_cnt < V_VIS;
  assign hs = h_cnt >= HS_BEG && h_cnt < HS_END;
  assign vs = v_cnt >= VS_BEG && v_cnt < VS_END;
  // index 0 is the raw flag, index n the flag delayed by n clocks
  assign act_v = {act_d, act};
  assign hs_v = {hs_d, hs};
  assign vs_v = {vs_d, vs};
  always_ff @(posedge vga_clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      h_cnt <= '0;
      v_cnt <= '0;
      frame_start_o <= 1'b0;
      act_d <= '0;
      hs_d <= '0;
      vs_d <= '0;
      rgb <= '0;
    end else begin
      h_cnt <= h_end ? '0 : h_cnt + 10'd1;
      if (h_end) v_cnt <= v_end ? '0 : v_cnt + 10'd1;
      frame_start_o <= h_end && v_end;
      act_d <= act_v[PIPE_DELAY-1:0];
      hs_d <= hs_v[PIPE_DELAY-1:0];
      vs_d <= vs_v[PIPE_DELAY-1:0];
      rgb <= act_v[PIPE_DELAY-1] ? RGB_i : '0;
    end
  assign x_pos_o = {22'd0, h_cnt};
  assign y_pos_o = {22'd0, v_cnt};
  assign hsync_o = ~hs_v[PIPE_DELAY];
  assign vsync_o = ~vs_v[PIPE_DELAY];
  assign blank_n_o = act_v[PIPE_DELAY];
  assign sync_n_o = 1'b0;
  assign {r_o, g_o, b_o} = rgb;
endmodule

// File: tb/tb_vga_timing_generator.sv
// tb_vga_timing_generator: two shrunken-raster instances (PIPE_DELAY 2 and 1)
// compared every clock against a k-indexed arithmetic model of the raster.
module tb_vga_timing_generator;
  localparam int HA = 16, HF = 2, HS = 3, HB = 4;
  localparam int VA = 6, VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int PD[2] = '{2, 1};
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [23:0] rgb_in[2];
  logic [31:0] x[2], y[2];
  logic hsync[2], vsync[2], blank_n[2], sync_n[2], fs[2];
  logic [7:0] r[2], g[2], b[2];
  int k = 0;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  vga_timing_generator #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .PIPE_DELAY(2)) u_pd2 (
    .vga_clk_i(clk), .rst_n_i(rst_n), .RGB_i(rgb_in[0]), .x_pos_o(x[0]), .y_pos_o(y[0]),
    .hsync_o(hsync[0]), .vsync_o(vsync[0]), .blank_n_o(blank_n[0]), .sync_n_o(sync_n[0]),
    .r_o(r[0]), .g_o(g[0]), .b_o(b[0]), .frame_start_o(fs[0]));
  vga_timing_generator #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .PIPE_DELAY(1)) u_pd1 (
    .vga_clk_i(clk), .rst_n_i(rst_n), .RGB_i(rgb_in[1]), .x_pos_o(x[1]), .y_pos_o(y[1]),
    .hsync_o(hsync[1]), .vsync_o(vsync[1]), .blank_n_o(blank_n[1]), .sync_n_o(sync_n[1]),
    .r_o(r[1]), .g_o(g[1]), .b_o(b[1]), .frame_start_o(fs[1]));
  function automatic int hpos(input int kk);
    return kk % HT;
  endfunction
  function automatic int vpos(input int kk);
    return (kk / HT) % VT;
  endfunction
  // a negative k is a delay stage still holding its reset value
  function automatic logic act_at(input int kk);
    return kk >= 0 && hpos(kk) < HA && vpos(kk) < VA;
  endfunction
  function automatic logic hs_at(input int kk);
    return kk >= 0 && hpos(kk) >= HA + HF && hpos(kk) < HA + HF + HS;
  endfunction
  function automatic logic vs_at(input int kk);
    return kk >= 0 && vpos(kk) >= VA + VF && vpos(kk) < VA + VF + VS;
  endfunction
  function automatic logic [23:0] colour(input int kk);
    int hh, vv;
    hh = hpos(kk);
    vv = vpos(kk);
    return {hh[7:0], vv[7:0], 8'hA5};
  endfunction
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s k=%0d: got %0h expected %0h", tag, k, obs, exp);
    end
  endtask
  task automatic drive();
    for (int i = 0; i < 2; i++) begin
      int src;
      src = k - PD[i] + 1;
      rgb_in[i] = act_at(src) ? colour(src) : ($urandom_range(1) ? 24'hFFFFFF : 24'($urandom));
    end
  endtask
  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      int d;
      string p;
      d = k - PD[i];
      p = $sformatf("pd%0d.", PD[i]);
      check({p, "x"}, x[i], 32'(hpos(k)));
      check({p, "y"}, y[i], 32'(vpos(k)));
      check({p, "hsync"}, 32'(hsync[i]), 32'(!hs_at(d)));
      check({p, "vsync"}, 32'(vsync[i]), 32'(!vs_at(d)));
      check({p, "blank_n"}, 32'(blank_n[i]), 32'(act_at(d)));
      check({p, "sync_n"}, 32'(sync_n[i]), 32'd0);
      check({p, "rgb"}, {8'd0, r[i], g[i], b[i]}, act_at(d) ? {8'd0, colour(d)} : 32'd0);
      check({p, "frame_start"}, 32'(fs[i]), 32'(k > 0 && k % FT == 0));
    end
  endtask
  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #1 k++;
      drive();
      @(negedge clk);
      check_all();
    end
  endtask
  initial begin
    drive();
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
    run(2 * FT + 7);
    repeat (2) begin
      run($urandom_range(1, FT));
      #2 rst_n = 1'b0;
      #1 k = 0;
      drive();
      check_all();
      repeat ($urandom_range(1, 4)) @(posedge clk);
      @(negedge clk);
      check_all();
      rst_n = 1'b1;
      run(2 * FT + 3);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
